// File: rtl/seq_vickrey_auction.sv
// Sequential second-price (Vickrey) auction: collects 2**N bids in index order,
// reports the highest bidder and the second-highest bid as the price paid.
//
// state   | meaning
// IDLE    | waiting for start; last results held on winner/win_price
// COLLECT | accepting one bid per bid_valid cycle, index 0..2**N-1
// DONE    | one-cycle done pulse with results valid
module seq_vickrey_auction #(
    parameter int N = 3,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         bid_valid,
    input  logic [W-1:0] bid,
    output logic         bid_ready,
    output logic [N-1:0] bid_idx,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] winner,
    output logic [W-1:0] win_price
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic [N-1:0] LAST_IDX = '1;

    state_t       state, state_nxt;
    logic [W-1:0] best, second;
    logic [W-1:0] best_nxt, second_nxt;
    logic [N-1:0] winner_nxt;
    logic         accept;
    logic         last_bid;

    always_comb begin
        state_nxt  = state;
        best_nxt   = best;
        second_nxt = second;
        winner_nxt = winner;
        accept     = (state == COLLECT) && bid_valid;
        last_bid   = (bid_idx == LAST_IDX);

        // Strictly-greater update keeps ties on the lowest index.
        if (bid > best) begin
            second_nxt = best;
            best_nxt   = bid;
            winner_nxt = bid_idx;
        end else if (bid > second) begin
            second_nxt = bid;
        end

        case (state)
            IDLE:    if (start) state_nxt = COLLECT;
            COLLECT: if (accept && last_bid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bid_ready = (state == COLLECT);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bid_idx   <= '0;
            best      <= '0;
            second    <= '0;
            winner    <= '0;
            win_price <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        bid_idx   <= '0;
                        best      <= '0;
                        second    <= '0;
                        winner    <= '0;
                        win_price <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        best    <= best_nxt;
                        second  <= second_nxt;
                        winner  <= winner_nxt;
                        bid_idx <= bid_idx + 1'b1;
                        // Capture with the final bid folded in so the price is valid during done.
                        if (last_bid) win_price <= second_nxt;
                    end
                end
                DONE: win_price <= second;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_vickrey_auction.sv
// Directed bench for seq_vickrey_auction: table of full auctions plus hand-written
// reset/abort, start-while-busy and N=1 sequences.
module tb_seq_vickrey_auction;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, bid_valid;
    logic [2:0] bid;
    logic       bid_ready, busy, done;
    logic [2:0] bid_idx, winner, win_price;

    logic       start2, bid_valid2;
    logic [3:0] bid2;
    logic       bid_ready2, busy2, done2;
    logic [0:0] bid_idx2, winner2;
    logic [3:0] win_price2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_vickrey_auction #(.N(3), .W(3)) u_dut (
        .clk(clk), .rst(rst), .start(start), .bid_valid(bid_valid), .bid(bid),
        .bid_ready(bid_ready), .bid_idx(bid_idx), .busy(busy), .done(done),
        .winner(winner), .win_price(win_price)
    );

    seq_vickrey_auction #(.N(1), .W(4)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .bid_valid(bid_valid2), .bid(bid2),
        .bid_ready(bid_ready2), .bid_idx(bid_idx2), .busy(busy2), .done(done2),
        .winner(winner2), .win_price(win_price2)
    );

    typedef struct {
        logic [7:0][2:0] bids;
        bit              gap;
        logic [2:0]      exp_win;
        logic [2:0]      exp_price;
        int              exp_lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0][2:0] mk(input int b0, input int b1, input int b2, input int b3,
                                          input int b4, input int b5, input int b6, input int b7);
        logic [7:0][2:0] r;
        r[0] = b0[2:0]; r[1] = b1[2:0]; r[2] = b2[2:0]; r[3] = b3[2:0];
        r[4] = b4[2:0]; r[5] = b5[2:0]; r[6] = b6[2:0]; r[7] = b7[2:0];
        return r;
    endfunction

    // Starts an auction at a negedge, feeds bids (optionally with a gap before each),
    // and checks latency counted in cycles from the start cycle.
    task automatic run_auction(input vec_t v);
        int k, cyc;
        bit g, got;
        start = 1'b1; bid_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; k = 0; g = 1'b0; got = 1'b0;
        while (!got && cyc <= 60) begin
            if (done) begin
                got = 1'b1;
                check("latency", cyc, v.exp_lat);
                check("winner", winner, v.exp_win);
                check("win_price", win_price, v.exp_price);
                check("busy_in_done", busy, 1);
            end else begin
                if (cyc == 1) begin
                    check("winner_cleared", winner, 0);
                    check("price_cleared", win_price, 0);
                    check("bid_ready_collect", bid_ready, 1);
                end
                check("bid_idx", bid_idx, k % 8);
                if (v.gap && !g) begin
                    bid_valid = 1'b0;
                end else begin
                    bid_valid = 1'b1;
                    bid = (k < 8) ? v.bids[k] : 3'd0;
                    k++;
                end
                g = !g;
                @(negedge clk);
                cyc++;
            end
        end
        bid_valid = 1'b0;
        if (!got) check("done_timeout", 0, 1);
        @(negedge clk);
        check("done_pulse_end", done, 0);
        check("idle_busy", busy, 0);
        check("hold_winner", winner, v.exp_win);
        check("hold_price", win_price, v.exp_price);
    endtask

    initial begin
        int timeout;
        bit saw_done;

        vecs[0] = '{bids: mk(6,0,1,4,3,7,5,2), gap: 1'b0, exp_win: 3'd5, exp_price: 3'd6, exp_lat: 9};
        vecs[1] = '{bids: mk(3,3,3,3,3,3,3,3), gap: 1'b0, exp_win: 3'd0, exp_price: 3'd3, exp_lat: 9};
        vecs[2] = '{bids: mk(0,0,0,0,0,0,0,0), gap: 1'b0, exp_win: 3'd0, exp_price: 3'd0, exp_lat: 9};
        vecs[3] = '{bids: mk(6,0,1,4,3,7,5,2), gap: 1'b1, exp_win: 3'd5, exp_price: 3'd6, exp_lat: 17};
        vecs[4] = '{bids: mk(7,7,0,0,0,0,0,0), gap: 1'b0, exp_win: 3'd0, exp_price: 3'd7, exp_lat: 9};
        vecs[5] = '{bids: mk(1,2,3,4,5,6,7,7), gap: 1'b0, exp_win: 3'd6, exp_price: 3'd7, exp_lat: 9};

        rst = 1'b1; start = 1'b0; bid_valid = 1'b0; bid = '0;
        start2 = 1'b0; bid_valid2 = 1'b0; bid2 = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_bid_ready", bid_ready, 0);
        check("rst_bid_idx", bid_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_winner", winner, 0);
        check("rst_price", win_price, 0);

        // bid_valid in IDLE is ignored
        bid_valid = 1'b1; bid = 3'd7;
        @(negedge clk);
        bid_valid = 1'b0;
        check("idle_ignore_busy", busy, 0);
        check("idle_ignore_idx", bid_idx, 0);

        for (int i = 0; i < 6; i++) run_auction(vecs[i]);

        // rst wins over start
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_clears_winner", winner, 0);
        check("rst_clears_price", win_price, 0);

        // start pulsed in COLLECT is ignored; rst after 4 accepts aborts with no done
        start = 1'b1;
        @(negedge clk);
        bid_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: bid = 3'd6;
                1: bid = 3'd0;
                2: bid = 3'd1;
                default: bid = 3'd7;
            endcase
            start = (i == 1 || i == 2);
            @(negedge clk);
        end
        bid_valid = 1'b0; start = 1'b0;
        check("mid_busy", busy, 1);
        check("mid_idx_after_start_pulse", bid_idx, 4);
        check("mid_winner", winner, 3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_bid_ready", bid_ready, 0);
        check("abort_idx", bid_idx, 0);
        check("abort_busy", busy, 0);
        check("abort_winner", winner, 0);
        check("abort_price", win_price, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort_no_done", saw_done, 0);
        run_auction(vecs[0]);

        // N=1, W=4: bids 2, 9
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; bid_valid2 = 1'b1; bid2 = 4'd2;
        @(negedge clk);
        bid2 = 4'd9;
        @(negedge clk);
        bid_valid2 = 1'b0;
        timeout = 0;
        while (!done2 && timeout < 20) begin
            @(negedge clk);
            timeout++;
        end
        check("n1_latency_extra", timeout, 0);
        check("n1_done", done2, 1);
        check("n1_winner", winner2, 1);
        check("n1_price", win_price2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_vickrey_auction.md
SEQ_VICKREY_AUCTION -- requirements
Module: seq_vickrey_auction

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning log2 of bidder count (2**N bidders, N >= 1).
REQ-002 The block SHALL have parameter W, default 3, meaning bid width in bits (unsigned, W >= 1).
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  begins a new auction; honoured only in IDLE.
REQ-007 bid_valid  input  1  bid presents a valid bid for the current bidder index.
REQ-008 bid  input  W  unsigned bid of bidder number bid_idx.
REQ-009 bid_ready  output  1  block accepts a bid this cycle.
REQ-010 bid_idx  output  N  index of the bidder whose bid is expected next.
REQ-011 busy  output  1  high in COLLECT and DONE states.
REQ-012 done  output  1  one-cycle pulse; results valid.
REQ-013 winner  output  N  index of highest bidder.
REQ-014 win_price  output  W  price paid = second-highest bid (Vickrey).

Function
REQ-015 The FSM SHALL have states IDLE, COLLECT, DONE.
REQ-016 IDLE: start=1 SHALL move to COLLECT next cycle and clear bid_idx, best, second, winner, win_price to 0.
REQ-017 COLLECT: bid_ready SHALL be 1; a bid is accepted on any cycle with bid_valid=1 and bid_ready=1; bid_valid=0 cycles stall with no state change.
REQ-018 Bids SHALL be accepted strictly in index order 0..2**N-1, one per accepting cycle; bid_idx increments on each accept.
REQ-019 On accept, if bid > best: second <= best, best <= bid, winner <= bid_idx.
REQ-020 On accept, else if bid > second: second <= bid (so an equal-to-best bid sets second = best).
REQ-021 Ties for highest SHALL resolve to the lowest index; winner is only updated on strictly greater.
REQ-022 Comparisons SHALL be unsigned W-bit; no widening or saturation.
REQ-023 Accepting bid index 2**N-1 SHALL move to DONE next cycle; bid_idx wraps to 0.
REQ-024 DONE SHALL last exactly one cycle with done=1, win_price <= second captured, then return to IDLE.
REQ-025 Latency: done SHALL assert the cycle after the final bid is accepted; minimum auction length 2**N+1 cycles after start.
REQ-026 winner and win_price SHALL hold their values in IDLE until the next start or reset.
REQ-027 start SHALL be ignored in COLLECT and DONE; bid_valid SHALL be ignored outside COLLECT (bid_ready=0).
REQ-028 start and rst asserted together: rst SHALL win.

Reset
REQ-029 rst=1 SHALL force IDLE and set bid_ready, bid_idx, busy, done, winner, win_price, best, second to 0 on the next edge, from any state.
REQ-030 rst mid-COLLECT SHALL abort the auction with no done pulse; already accepted bids are discarded.

Verification
REQ-031 N=3,W=3, bids 6,0,1,4,3,7,5,2 back-to-back -> done 9 cycles after start, winner=5, win_price=6.
REQ-032 All eight bids = 3 -> winner=0, win_price=3; bids 0,...,0 -> winner=0, win_price=0.
REQ-033 Same bids as REQ-031 with bid_valid low every other cycle -> identical result, done 17 cycles after start, bid_idx holds during gaps.
REQ-034 start pulsed during COLLECT and rst asserted after 4 accepts -> start ignored; after rst all outputs 0, no done; fresh auction then completes correctly.
REQ-035 Bids 7,7,0,0,0,0,0,0 -> winner=0, win_price=7; N=1,W=4 bids 2,9 -> winner=1, win_price=2.
